rsa_result_collector: RTL and testbench

Receiving end of the systolic array's result stream. It drives `out_rdy`, accepts `out_val`/`out_data` beats into a ROWS×COLS result buffer and signals `done` when a full result matrix has been captured. The host then reads the results back through a registered random-access port. It sits between the array's output port and the host/next stage, replacing the permanently-ready sink used in bring-up.

---
 rtl/rsa_result_collector.sv | 133 +++++++++++++
 tb/tb_rsa_result_collector.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rsa_result_collector.sv
// Result sink for the systolic array: captures ROWS*COLS beats into a register buffer, raises done, serves 1-cycle registered reads.
// Latency: out_rdy/busy one cycle after start, done one cycle after the last beat, read data one cycle after rd_en.
// Backpressure: out_rdy is high only while collecting. Define RSA_COLLECT_TRANSPOSE_EN to store the matrix column-major.
module rsa_result_collector #(
    parameter int OUT_LEN    = 8,
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  out_val,
    input  logic [OUT_LEN-1:0]    out_data,
    output logic                  out_rdy,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   beat_cnt,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [OUT_LEN-1:0]    rd_data,
    output logic                  rd_val
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = ROWS * COLS;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LAST_W   = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(ROWS);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [OUT_LEN-1:0]    rd_data_q, rd_data_d;
    logic                  rd_val_q, rd_val_d;
    logic [OUT_LEN-1:0]    mem_q [DEPTH];
    logic                  xfer;

    assign xfer = (state_q == COLLECT) && out_val;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_ptr_d   = wr_ptr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = COLLECT;
                    beat_cnt_d = '0;
                    row_d      = '0;
                    col_d      = '0;
                    wr_ptr_d   = '0;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    beat_cnt_d = (beat_cnt_q == DEPTH_W) ? beat_cnt_q : beat_cnt_q + CW'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ONE_A;
                    end else begin
                        col_d = col_q + ONE_A;
                    end
`ifdef RSA_COLLECT_TRANSPOSE_EN
                    // Column-major: stride by ROWS, rewind to the next row's first column slot on wrap.
                    wr_ptr_d = (col_q == COL_LAST) ? row_q + ONE_A : wr_ptr_q + ROW_STEP;
`else
                    wr_ptr_d = wr_ptr_q + ONE_A;
`endif
                    if (beat_cnt_q == LAST_W) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val_d  = rd_en;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = ({1'b0, rd_addr} < DEPTH_W) ? mem_q[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wr_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_val_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_val_q   <= rd_val_d;
        end
    end

    // Buffer is deliberately not reset; reads of the same slot in the write cycle see old data.
    always_ff @(posedge clk) begin
        if (xfer && !sys_rst) begin
            mem_q[wr_ptr_q] <= out_data;
        end
    end

    assign out_rdy  = (state_q == COLLECT);
    assign busy     = (state_q == COLLECT);
    assign done     = (state_q == DONE);
    assign beat_cnt = beat_cnt_q;
    assign rd_data  = rd_data_q;
    assign rd_val   = rd_val_q;

endmodule

// File: tb/tb_rsa_result_collector.sv
// Randomised bench for rsa_result_collector against a matrix-level reference model.
module tb_rsa_result_collector;
    localparam int OUT_LEN = 8;
    localparam int ROWS    = 3;
    localparam int COLS    = 3;
    localparam int AW      = 4;
    localparam int DEPTH   = ROWS * COLS;
`ifdef RSA_COLLECT_TRANSPOSE_EN
    localparam bit TRANSPOSE = 1'b1;
`else
    localparam bit TRANSPOSE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic               start = 1'b0;
    logic               out_val = 1'b0;
    logic [OUT_LEN-1:0] out_data = '0;
    logic               out_rdy;
    logic               busy;
    logic               done;
    logic [AW:0]        beat_cnt;
    logic               rd_en = 1'b0;
    logic [AW-1:0]      rd_addr = '0;
    logic [OUT_LEN-1:0] rd_data;
    logic               rd_val;

    always #5 clk = ~clk;

    rsa_result_collector #(
        .OUT_LEN(OUT_LEN), .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start),
        .out_val(out_val), .out_data(out_data), .out_rdy(out_rdy),
        .busy(busy), .done(done), .beat_cnt(beat_cnt),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_val(rd_val)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a matrix being filled in arrival order.
    bit         m_collect = 1'b0;
    bit         m_done    = 1'b0;
    int         m_cnt     = 0;
    logic [7:0] m_mem   [DEPTH];
    bit         m_known [DEPTH];
    bit         e_rd_val  = 1'b0;
    logic [7:0] e_rd_data = '0;
    bit         e_rd_chk  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int map_addr(input int k);
        if (TRANSPOSE) return (k % COLS) * ROWS + k / COLS;
        return k;
    endfunction

    task automatic step(input logic st, input logic v, input logic [7:0] d,
                        input logic re, input logic [AW-1:0] ra, input logic rst);
        start = st; out_val = v; out_data = d; rd_en = re; rd_addr = ra; sys_rst = rst;
        check("out_rdy", 32'(out_rdy), 32'(m_collect));
        check("busy", 32'(busy), 32'(m_collect));
        check("done", 32'(done), 32'(m_done));
        check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
        if (rst) begin
            m_collect = 0; m_done = 0; m_cnt = 0;
            e_rd_val = 0; e_rd_data = '0; e_rd_chk = 1;
            for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        end else begin
            e_rd_val = re;
            e_rd_chk = 0;
            if (re) begin
                if (int'(ra) >= DEPTH) begin
                    e_rd_data = '0; e_rd_chk = 1;
                end else begin
                    e_rd_data = m_mem[ra]; e_rd_chk = m_known[ra];
                end
            end
            if (m_collect && v) begin
                m_mem[map_addr(m_cnt)]   = d;
                m_known[map_addr(m_cnt)] = 1;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_collect = 0; m_done = 1;
                end
            end else if (st && !m_collect) begin
                m_collect = 1; m_done = 0; m_cnt = 0;
            end
        end
        @(posedge clk); #1;
        check("rd_val", 32'(rd_val), 32'(e_rd_val));
        if (e_rd_chk) check("rd_data", 32'(rd_data), 32'(e_rd_data));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, 8'h00, 1'b1, AW'(a), 1'b0);
    endtask

    // Random collection: random valid/start/reads; optionally assert start with the final beat.
    task automatic rand_collect(input bit start_on_last);
        step(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        for (int c = 0; c < 200 && !m_done; c++) begin
            logic v, st;
            v  = 1'($urandom_range(0, 2) != 0);
            st = 1'($urandom_range(0, 5) == 0);
            if (start_on_last && m_cnt == DEPTH - 1) begin
                v = 1'b1; st = 1'b1;
            end
            step(st, v, 8'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 0; m_mem[i] = '0;
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b1);
        idle_step();

        // Valid 0xAA before start must be ignored.
        repeat (3) step(1'b0, 1'b1, 8'hAA, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0, '0, 1'b0);
        for (int k = 1; k <= DEPTH; k++) step(1'b0, 1'b1, 8'(k), 1'b0, '0, 1'b0);
        idle_step();
        read_all();
        step(1'b0, 1'b0, 8'h00, 1'b1, AW'(12), 1'b0);

        // Valid 0xAA after done must be ignored too.
        repeat (3) step(1'b0, 1'b1, 8'hAA, 1'b1, AW'($urandom_range(0, 15)), 1'b0);
        read_all();

        // Restart from DONE, out_val toggled every other cycle.
        step(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            step(1'b0, 1'(n % 2 == 0), 8'($urandom), 1'b0, '0, 1'b0);
            n++;
        end
        check("toggle_latency", 32'(n), 32'd17);
        read_all();

        // Reset after beat 4, then a fresh collection.
        step(1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0, '0, 1'b1);
        idle_step();
        rand_collect(1'b0);
        idle_step();
        read_all();

        // Start coinciding with the final beat, then several random rounds.
        rand_collect(1'b1);
        idle_step();
        read_all();
        repeat (4) begin
            rand_collect(1'b0);
            repeat (2) step(1'b0, 1'($urandom_range(0, 1)), 8'hAA, 1'b1, AW'($urandom_range(0, 15)), 1'b0);
            read_all();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
